mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_CAPACITY, default 4096, meaning RAM size in bytes.
REQ-002 SHALL have port m_clock input 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port p_reset input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid input 1: request present.
REQ-005 SHALL have port req_ready output 1: unit accepts a request this cycle.
REQ-006 SHALL have port req_we input 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned input 1: load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr input 32: byte address.
REQ-010 SHALL have port req_wdata input 32: store data, right-justified.
REQ-011 SHALL have port resp_valid output 1: response present.
REQ-012 SHALL have port resp_ready input 1: consumer takes the response.
REQ-013 SHALL have port resp_rdata output 32: load result (0 for stores and errors).
REQ-014 SHALL have port resp_err output 1: misaligned, out-of-range or reserved-size request.
REQ-015 SHALL have port addr_r output 32: RAM read address; 4 little-endian bytes, returned combinationally.
REQ-016 SHALL have port rdata input 32: RAM read data.
REQ-017 SHALL have port addr_w output 32: RAM write address.
REQ-018 SHALL have port wdata output 32: RAM write data; 4 bytes at addr_w..addr_w+3.
REQ-019 SHALL have port we output 1: RAM write enable, sampled by the RAM on the m_clock edge.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-022 SHALL latch addr, size, we, unsigned and wdata on acceptance.
REQ-023 SHALL flag an error at acceptance when any of these hold: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr > MEM_CAPACITY-4.
  - Error transitions: IDLE -> RESP with resp_err=1 and no RAM write.
REQ-024 SHALL transition IDLE -> READ on a valid request, and drive addr_r = latched addr during READ.
REQ-025 SHALL capture rdata into a word register at the end of READ.
REQ-026 SHALL, for a load, transition READ -> RESP.
  - resp_rdata = byte or half extracted from bits [7:0] or [15:0].
  - Extension per req_unsigned; word loads pass through unchanged.
REQ-027 SHALL, for a store, transition READ -> WRITE, asserting we=1 for exactly one cycle with addr_w = latched addr.
  - wdata = captured word with low 8/16/32 bits replaced by req_wdata (read-modify-write).
  - WRITE then transitions to RESP.
REQ-028 SHALL hold we=0 in every state other than WRITE.
  - addr_w and wdata SHALL be 0 outside WRITE.
REQ-029 SHALL hold resp_valid=1 in RESP and keep resp_rdata/resp_err stable until resp_ready=1.
  - RESP -> IDLE on that edge; back-to-back requests are accepted no earlier than the following cycle.
REQ-030 SHALL give these latencies, from the accept edge to the first cycle resp_valid=1:
  - load: 2 cycles
  - store: 3 cycles
  - error: 1 cycle
REQ-031 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-032 SHALL, on p_reset=0, immediately set state=IDLE and all internal registers to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, we=0, addr_r=0, addr_w=0, wdata=0.
REQ-033 SHALL abort any in-flight request on reset: no write issued, no response produced.
REQ-034 SHALL not treat the first rising m_clock edge after reset deassertion as special; it may accept a request.

Structure
REQ-035 SHALL place the following in shared package mem_access_pkg:
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state encoding
  - default MEM_CAPACITY
REQ-036 SHALL isolate load extraction and store merge in one combinational sub-module, mem_align (inputs: word, size, unsigned, wdata; outputs: load value, merged word).

Verification
REQ-037 SHALL verify a store word: 0xDEADBEEF to addr 0x10 -> we high exactly one cycle; RAM bytes 0x10..0x13 = EF BE AD DE; response at accept+3 with resp_err=0.
REQ-038 SHALL verify a byte store then load: RAM word 0x11223344 at 0x20; store byte 0xAA to 0x20 -> RAM word 0x112233AA; signed byte load from 0x20 -> resp_rdata 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-039 SHALL verify a halfword load: RAM 0x80001234 at 0x40; signed half load -> 0x00001234; word load -> 0x80001234 at accept+2.
REQ-040 SHALL verify errors:
  - half load at 0x41, word store at 0x42, size=11, or word at 0xFFD -> resp_err=1 at accept+1.
  - we never asserted; RAM unchanged.
REQ-041 SHALL verify backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0 throughout.
REQ-042 SHALL verify reset mid-store: assert p_reset=0 during READ of a store -> we never asserted, RAM unchanged, outputs at reset values immediately.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM encoding,
// default RAM capacity.
package mem_access_pkg;

   localparam int MEM_CAPACITY_DEFAULT = 4096;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_align.sv
// Load extraction (byte/half/word with sign or zero extension) and
// read-modify-write merge of store data into the captured RAM word.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   // Size-dependent extraction and merge; low lanes always hold the access.
   always_comb begin
      load_o  = word_i;
      merge_o = wdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_o  = uns_i ? {24'h0, word_i[7:0]} : {{24{word_i[7]}}, word_i[7:0]};
            merge_o = {word_i[31:8], wdata_i[7:0]};
         end
         SZ_HALF: begin
            load_o  = uns_i ? {16'h0, word_i[15:0]} : {{16{word_i[15]}}, word_i[15:0]};
            merge_o = {word_i[31:16], wdata_i[15:0]};
         end
         default: begin
            load_o  = word_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store unit in front of a little-endian RAM.
// Stores are read-modify-write so byte/half stores keep neighbouring lanes.
//
// state | meaning
// IDLE  | ready for a request; bad requests go straight to RESP
// READ  | addr_r driven, RAM word captured at end of cycle
// WRITE | one-cycle write of the merged word (stores only)
// RESP  | response held until resp_ready
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_CAPACITY = MEM_CAPACITY_DEFAULT
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] addr_r,
   input  logic [31:0] rdata,
   output logic [31:0] addr_w,
   output logic [31:0] wdata,
   output logic        we
);

   localparam logic [31:0] LAST_WORD = 32'(MEM_CAPACITY - 4);

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        store_q;
   logic        uns_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] word_q;
   logic        req_err;
   logic        accept;
   logic [31:0] load_word;
   logic [31:0] merge_word;

   assign accept = (state_q == IDLE) && req_valid;

   // Request legality: reserved size, misalignment, or past the last full word.
   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
      if (req_addr > LAST_WORD) req_err = 1'b1;
   end

   // State register, request latch and RAM word capture.
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         store_q <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            store_q <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            err_q   <= req_err;
         end
         if (state_q == READ) word_q <= rdata;
      end
   end

   mem_align u_align (
      .word_i  (word_q),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .wdata_i (wdata_q),
      .load_o  (load_word),
      .merge_o (merge_word)
   );

   // Next state and all outputs; RAM-side ports are zero outside their state.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      addr_r     = '0;
      addr_w     = '0;
      wdata      = '0;
      we         = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = req_err ? RESP : READ;
         end
         READ: begin
            addr_r  = addr_q;
            state_d = store_q ? WRITE : RESP;
         end
         WRITE: begin
            we      = 1'b1;
            addr_w  = addr_q;
            wdata   = merge_word;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || store_q) ? 32'h0 : load_word;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 4 KiB little-endian RAM model.
module tb_mem_access_unit;

   logic        m_clock;
   logic        p_reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] addr_r;
   logic [31:0] rdata;
   logic [31:0] addr_w;
   logic [31:0] wdata;
   logic        we;

   bit [7:0]    mem [0:4095];
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;
   int          we_cnt;
   int          n_cmp;
   int          n_mis;

   mem_access_unit #(.MEM_CAPACITY(4096)) dut (
      .m_clock      (m_clock),
      .p_reset      (p_reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .addr_r       (addr_r),
      .rdata        (rdata),
      .addr_w       (addr_w),
      .wdata        (wdata),
      .we           (we)
   );

   initial m_clock = 1'b0;
   always #5 m_clock = ~m_clock;

   wire [11:0] ra = addr_r[11:0];
   wire [11:0] wa = addr_w[11:0];
   assign rdata = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};

   // RAM write port (DUT) and preload port (bench), plus write-pulse counter.
   always @(posedge m_clock) begin
      if (we === 1'b1) begin
         we_cnt <= we_cnt + 1;
         mem[wa]          <= wdata[7:0];
         mem[wa + 12'd1]  <= wdata[15:8];
         mem[wa + 12'd2]  <= wdata[23:16];
         mem[wa + 12'd3]  <= wdata[31:24];
      end else if (pre_en) begin
         mem[pre_addr]          <= pre_data[7:0];
         mem[pre_addr + 12'd1]  <= pre_data[15:8];
         mem[pre_addr + 12'd2]  <= pre_data[23:16];
         mem[pre_addr + 12'd3]  <= pre_data[31:24];
      end
   end

   function automatic logic [31:0] ram_word(input logic [11:0] a);
      return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preset(input logic [11:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(posedge m_clock); #1;
      pre_en   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/req_ready"},  32'(req_ready),  32'd1);
      check({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "/resp_err"},   32'(resp_err),   32'd0);
      check({tag, "/resp_rdata"}, resp_rdata,      32'd0);
      check({tag, "/we"},         32'(we),         32'd0);
      check({tag, "/addr_r"},     addr_r,          32'd0);
      check({tag, "/addr_w"},     addr_w,          32'd0);
      check({tag, "/wdata"},      wdata,           32'd0);
   endtask

   // One full transaction: accept, measure latency, check response, release.
   task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rd);
      int lat;
      int we0;
      check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_we       = w;
      req_size     = sz;
      req_unsigned = u;
      req_addr     = a;
      req_wdata    = wd;
      we0          = we_cnt;
      @(posedge m_clock); #1;
      req_valid    = 1'b0;
      req_wdata    = 32'hFFFF_FFFF;
      req_addr     = 32'h0000_0F00;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(posedge m_clock); #1;
         lat++;
      end
      check({tag, "/latency"},    32'(lat),        32'(exp_lat));
      check({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "/resp_err"},   32'(resp_err),   32'(exp_err));
      check({tag, "/resp_rdata"}, resp_rdata,      exp_rd);
      check({tag, "/busy"},       32'(req_ready),  32'd0);
      check({tag, "/we_pulses"},  32'(we_cnt - we0), (w && !exp_err) ? 32'd1 : 32'd0);
      resp_ready = 1'b1;
      @(posedge m_clock); #1;
      resp_ready = 1'b0;
      check({tag, "/released"},   32'(resp_valid), 32'd0);
   endtask

   initial begin
      int we0;
      n_cmp = 0;
      n_mis = 0;
      we_cnt = 0;
      pre_en = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      p_reset = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      resp_ready = 1'b0;

      repeat (2) @(posedge m_clock);
      #1;
      check_reset_outputs("reset");
      p_reset = 1'b1;

      // Word store, then RAM byte order
      do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 3, 1'b0, 32'h0);
      check("st_word/ram", ram_word(12'h010), 32'hDEAD_BEEF);
      check("st_word/byte10", 32'(mem[12'h010]), 32'h0000_00EF);
      check("st_word/byte13", 32'(mem[12'h013]), 32'h0000_00DE);

      // Byte store merge, then signed/unsigned byte loads
      preset(12'h020, 32'h1122_3344);
      do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_00AA, 3, 1'b0, 32'h0);
      check("st_byte/ram", ram_word(12'h020), 32'h1122_33AA);
      do_req("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'hFFFF_FFAA);
      do_req("ld_byte_u", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 2, 1'b0, 32'h0000_00AA);

      // Halfword and word loads, half store merge
      preset(12'h040, 32'h8000_1234);
      preset(12'h044, 32'hCAFE_0000);
      do_req("ld_half_s40", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h0000_1234);
      do_req("ld_word40",   1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h8000_1234);
      do_req("ld_half_s42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 2, 1'b0, 32'hFFFF_8000);
      do_req("ld_half_u42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 2, 1'b0, 32'h0000_8000);
      do_req("st_half44",   1'b1, 2'b01, 1'b0, 32'h44, 32'h1234_BEEF, 3, 1'b0, 32'h0);
      check("st_half44/ram", ram_word(12'h044), 32'hCAFE_BEEF);
      do_req("ld_byte_s47", 1'b0, 2'b00, 1'b0, 32'h47, 32'h0, 2, 1'b0, 32'hFFFF_FFCA);

      // Error cases and address boundary
      do_req("err_half41",  1'b0, 2'b01, 1'b0, 32'h41,  32'h0, 1, 1'b1, 32'h0);
      do_req("err_word42",  1'b1, 2'b10, 1'b0, 32'h42,  32'hA5A5_A5A5, 1, 1'b1, 32'h0);
      check("err_word42/ram40", ram_word(12'h040), 32'h8000_1234);
      check("err_word42/ram44", ram_word(12'h044), 32'hCAFE_BEEF);
      do_req("err_size3",   1'b1, 2'b11, 1'b0, 32'h50,  32'h5555_5555, 1, 1'b1, 32'h0);
      check("err_size3/ram50", ram_word(12'h050), 32'h0);
      do_req("err_wordFFD", 1'b0, 2'b10, 1'b0, 32'hFFD, 32'h0, 1, 1'b1, 32'h0);
      do_req("err_word1000",1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 1'b1, 32'h0);
      do_req("err_byteFFD", 1'b0, 2'b00, 1'b0, 32'hFFD, 32'h0, 1, 1'b1, 32'h0);
      preset(12'hFFC, 32'h0BAD_F00D);
      do_req("ld_wordFFC",  1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 2, 1'b0, 32'h0BAD_F00D);

      // Backpressure: response held, new requests ignored
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h0;
      @(posedge m_clock); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD_0BAD;
      @(posedge m_clock); #1;
      we0 = we_cnt;
      for (int i = 0; i < 5; i++) begin
         check("bp/resp_valid", 32'(resp_valid), 32'd1);
         check("bp/resp_rdata", resp_rdata,      32'hDEAD_BEEF);
         check("bp/resp_err",   32'(resp_err),   32'd0);
         check("bp/req_ready",  32'(req_ready),  32'd0);
         @(posedge m_clock); #1;
      end
      req_valid = 1'b0;
      check("bp/no_write", 32'(we_cnt - we0), 32'd0);
      resp_ready = 1'b1;
      @(posedge m_clock); #1;
      resp_ready = 1'b0;
      check("bp/released", 32'(resp_valid), 32'd0);
      check("bp/ram10", ram_word(12'h010), 32'hDEAD_BEEF);

      // Reset during READ of a store
      preset(12'h060, 32'h0);
      we0 = we_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h60; req_wdata = 32'h1234_5678;
      @(posedge m_clock); #1;
      req_valid = 1'b0;
      check("rst_mid/addr_r", addr_r, 32'h60);
      p_reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge m_clock);
      #1;
      p_reset = 1'b1;
      check("rst_mid/no_write", 32'(we_cnt - we0), 32'd0);
      check("rst_mid/ram60", ram_word(12'h060), 32'h0);
      check("rst_mid/no_resp", 32'(resp_valid), 32'd0);
      do_req("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 2, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
